display_scan_ctrl: RTL



---
 rtl/display_scan_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Scan/mode controller for the two shared-segment 7-segment digits: latches the
// decoder result, debounces the button and multiplexes the anodes with blanking.
module display_scan_ctrl #(
  parameter int DIGIT_CYCLES    = 27000,
  parameter int BLANK_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       data_valid,
  input  logic [3:0] bin,
  input  logic [2:0] sin,
  output logic [3:0] bin_q,
  output logic [2:0] sin_q,
  output logic       digit_sel,
  output logic [1:0] an,
  output logic [1:0] mode,
  output logic [1:0] scan_state
);

  localparam int SCAN_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int SW       = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
  localparam int DW       = $clog2(DEBOUNCE_CYCLES);

  localparam logic [SW-1:0] DIGIT_LAST = SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PRE_SIN  = 2'd0,
    SHOW_SIN = 2'd1,
    PRE_BIN  = 2'd2,
    SHOW_BIN = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    M_AUTO = 2'd0,
    M_SIN  = 2'd1,
    M_BIN  = 2'd2
  } mode_e;

  logic [3:0]  bin_d;
  logic [2:0]  sin_d;
  logic        sync1_q, sync1_d;
  logic        btn_s_q, btn_s_d;
  logic        btn_db_q, btn_db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic        press_q, press_d;
  mode_e       mode_q, mode_d;
  scan_state_e state_q, state_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [SW-1:0] scan_last;
  logic [1:0]  an_q, an_d;
  logic        digit_sel_q, digit_sel_d;

  always_comb begin
    bin_d    = data_valid ? bin : bin_q;
    sin_d    = data_valid ? sin : sin_q;
    sync1_d  = btn;
    btn_s_d  = sync1_q;

    // Counter only runs while the synchronized level disagrees with the accepted one.
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s_q;
        press_d  = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end

    mode_d = mode_q;
    if (press_q) begin
      case (mode_q)
        M_AUTO:  mode_d = M_SIN;
        M_SIN:   mode_d = M_BIN;
        default: mode_d = M_AUTO;
      endcase
    end

    scan_last  = (state_q == SHOW_SIN || state_q == SHOW_BIN) ? DIGIT_LAST : BLANK_LAST;
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    if (press_q || mode_q != M_AUTO) begin
      state_d    = PRE_SIN;
      scan_cnt_d = '0;
    end else if (scan_cnt_q == scan_last) begin
      scan_cnt_d = '0;
      case (state_q)
        PRE_SIN:  state_d = SHOW_SIN;
        SHOW_SIN: state_d = PRE_BIN;
        PRE_BIN:  state_d = SHOW_BIN;
        default:  state_d = PRE_SIN;
      endcase
    end else begin
      scan_cnt_d = scan_cnt_q + SW'(1);
    end

    // Outputs decoded from next state so they are registered alongside it.
    case (mode_d)
      M_SIN: begin
        an_d        = 2'b01;
        digit_sel_d = 1'b0;
      end
      M_BIN: begin
        an_d        = 2'b10;
        digit_sel_d = 1'b1;
      end
      default: begin
        case (state_d)
          PRE_SIN:  begin an_d = 2'b00; digit_sel_d = 1'b0; end
          SHOW_SIN: begin an_d = 2'b01; digit_sel_d = 1'b0; end
          PRE_BIN:  begin an_d = 2'b00; digit_sel_d = 1'b1; end
          default:  begin an_d = 2'b10; digit_sel_d = 1'b1; end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      sin_q       <= '0;
      sync1_q     <= 1'b0;
      btn_s_q     <= 1'b0;
      btn_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      mode_q      <= M_AUTO;
      state_q     <= PRE_SIN;
      scan_cnt_q  <= '0;
      an_q        <= 2'b00;
      digit_sel_q <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      sin_q       <= sin_d;
      sync1_q     <= sync1_d;
      btn_s_q     <= btn_s_d;
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      mode_q      <= mode_d;
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      an_q        <= an_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign an         = an_q;
  assign digit_sel  = digit_sel_q;
  assign mode       = mode_q;
  assign scan_state = state_q;

endmodule
